// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional signed-overflow output is enabled by SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_DEF = 8;

    function automatic int sa_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder cell driven by the serial controller.
// Optional signed-overflow output is enabled by SERIAL_ADD_OVF_EN.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f,
    output logic c1
);

    assign f  = a ^ b ^ c;
    assign c1 = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first operand feed into fa_bit.
// Optional signed-overflow output ovf is enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = sa_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-2:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_f;
    logic             w_c1;
    logic [WIDTH-1:0] w_acc_sh;

    fa_bit u_fa (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .c  (r_carry),
        .f  (w_f),
        .c1 (w_c1)
    );

    // acc keeps only the upper WIDTH-1 bits; the new sum bit enters on top
    assign w_acc_sh = {w_f, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_sa    <= op_a;
                        r_sb    <= op_b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_sh[WIDTH-1:1];
                    r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
                    r_carry <= w_c1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_acc_sh;
                        r_cout  <= w_c1;
`ifdef SERIAL_ADD_OVF_EN
                        // carry flop here is the carry into the MSB
                        r_ovf   <= r_carry ^ w_c1;
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t tbl[6];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer addition and signed range test
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output logic [W-1:0] s,
                         output logic co, output logic ov);
        int u;
        int sg;
        u  = int'(a) + int'(b) + int'(c);
        sg = int'($signed(a)) + int'($signed(b)) + int'(c);
        s  = W'(u % (1 << W));
        co = (u >= (1 << W));
        ov = (sg > 127) || (sg < -128);
    endtask

    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] es,
                          input logic ec, input logic eo,
                          input bit glitch, input string nm);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        check({nm, " busy@accept"}, 32'(busy), 32'd1);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (i < W) begin
                check({nm, " run busy/done"}, {30'd0, busy, done}, 32'd2);
                if (glitch && i >= 2 && i <= 4) begin
                    start = 1'b1;
                    op_a  = W'($urandom);
                    op_b  = W'($urandom);
                    cin   = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end else begin
                check({nm, " done latency"}, {30'd0, busy, done}, 32'd1);
                check({nm, " sum"}, 32'(sum), 32'(es));
                check({nm, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
                check({nm, " ovf"}, 32'(ovf), 32'(eo));
`endif
            end
        end
        @(posedge clk);
        #1;
        check({nm, " done pulse"}, {30'd0, busy, done}, 32'd0);
        last_sum  = es;
        last_cout = ec;
    endtask

    initial begin
        logic [W-1:0] s, s2;
        logic co, ov, co2, ov2;
        logic [W-1:0] a2, b2;
        int n;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            do_add(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].es, tbl[i].ec,
                   tbl[i].eo, 1'b0, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            a2 = W'($urandom);
            b2 = W'($urandom);
            co = 1'($urandom);
            model(a2, b2, co, s, co2, ov);
            do_add(a2, b2, co, s, co2, ov, 1'b0, $sformatf("rnd%0d", i));
        end

        model(8'h3C, 8'hA5, 1'b1, s, co, ov);
        do_add(8'h3C, 8'hA5, 1'b1, s, co, ov, 1'b1, "ignore_start");

        // back-to-back: start held through the DONE cycle
        model(8'h12, 8'hF0, 1'b0, s, co, ov);
        model(8'h99, 8'h77, 1'b1, s2, co2, ov2);
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'hF0;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
        check("b2b first latency", 32'(n), 32'(W));
        check("b2b first sum", 32'(sum), 32'(s));
        check("b2b first cout", 32'(cout), 32'(co));
        op_a = 8'h99;
        op_b = 8'h77;
        cin  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 8'h00;
        check("b2b no idle", {30'd0, busy, done}, 32'd2);
        n = 1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
        check("b2b done spacing", 32'(n), 32'(W + 1));
        check("b2b second sum", 32'(sum), 32'(s2));
        check("b2b second cout", 32'(cout), 32'(co2));
`ifdef SERIAL_ADD_OVF_EN
        check("b2b second ovf", 32'(ovf), 32'(ov2));
`endif
        @(posedge clk);
        #1;

        // mid-run asynchronous reset
        @(negedge clk);
        op_a  = 8'hC3;
        op_b  = 8'h4E;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst idle", {30'd0, busy, done}, 32'd0);
        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "after_rst");

        model(8'hE7, 8'h5B, 1'b0, s, co, ov);
        do_add(8'hE7, 8'h5B, 1'b0, s, co, ov, 1'b0, "pre_hold");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
            @(posedge clk);
            #1;
            check("hold sum", 32'(sum), 32'(last_sum));
            check("hold cout/done", {30'd0, cout, done},
                  {30'd0, last_cout, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
